// File: rtl/npu_csr_pkg.sv
// Shared definitions for the NPU CSR slave: register word map, CTRL/STATUS bit
// positions, AXI response codes and the small state enums used by the channel FSMs.
package npu_csr_pkg;

  // Word indices (byte offset >> 2) of the fixed registers; CFG[i] sits at REG_CFG_BASE + i
  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_CYCLES   = 2;
  localparam int REG_VERSION  = 3;
  localparam int REG_CFG_BASE = 4;

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    WR_COLLECT,   // AW/W holding slots accept beats independently
    WR_RESP       // register updated, B response pending
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_e;

  // True when a word index falls inside the implemented register map
  function automatic logic word_in_map(input logic [31:0] widx, input int n_cfg);
    return widx < 32'(REG_CFG_BASE + n_cfg);
  endfunction

endpackage

// File: rtl/npu_csr_axil.sv
// AXI4-Lite CSR slave for the conv NPU: config registers, start/soft-reset pulses,
// BUSY/DONE/ERR tracking, job cycle counter and a registered level interrupt.
module npu_csr_axil
  import npu_csr_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 8,
  parameter int          N_CFG   = 8,
  parameter logic [31:0] VERSION = DEFAULT_VERSION
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic [ADDR_W-1:0]       s00_axi_awaddr,
  input  logic [2:0]              s00_axi_awprot,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_W-1:0]       s00_axi_wdata,
  input  logic [DATA_W/8-1:0]     s00_axi_wstrb,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ADDR_W-1:0]       s00_axi_araddr,
  input  logic [2:0]              s00_axi_arprot,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [DATA_W-1:0]       s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready,
  output logic                    start_o,
  output logic                    soft_rst_o,
  output logic [N_CFG*DATA_W-1:0] cfg_o,
  input  logic                    done_i,
  input  logic                    err_i,
  output logic                    irq_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WIDX_W = ADDR_W - 2;

  // Protection bits and byte-lane address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Channel state
  logic              active_reg;
  wr_state_e         wr_state_reg, wr_state_next;
  rd_state_e         rd_state_reg, rd_state_next;
  logic              aw_full_reg;
  logic [WIDX_W-1:0] aw_widx_reg;
  logic              w_full_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [STRB_W-1:0] w_strb_reg;
  axi_resp_e         bresp_reg;
  logic [DATA_W-1:0] rdata_reg;
  axi_resp_e         rresp_reg;

  logic aw_ready, w_ready, ar_ready, wr_commit;
  logic aw_hs, w_hs, ar_hs;

  // Register file state
  logic              irq_en_reg, busy_reg, done_reg, err_reg, irq_reg;
  logic              start_reg, soft_rst_reg;
  logic [DATA_W-1:0] cycles_reg;

  // Commit decode
  logic [31:0] wr_widx, rd_widx;
  logic        wr_in_map, ctrl_wr, status_wr, start_req, soft_rst_req;
  logic [DATA_W-1:0] rd_data;
  axi_resp_e         rd_resp;

  assign aw_hs = s00_axi_awvalid && aw_ready;
  assign w_hs  = s00_axi_wvalid && w_ready;
  assign ar_hs = s00_axi_arvalid && ar_ready;

  assign wr_widx      = 32'(aw_widx_reg);
  assign wr_in_map    = word_in_map(wr_widx, N_CFG);
  assign ctrl_wr      = wr_commit && (wr_widx == 32'(REG_CTRL)) && w_strb_reg[0];
  assign status_wr    = wr_commit && (wr_widx == 32'(REG_STATUS)) && w_strb_reg[0];
  assign soft_rst_req = ctrl_wr && w_data_reg[CTRL_SOFT_RST];
  assign start_req    = ctrl_wr && w_data_reg[CTRL_START] && !soft_rst_req;

  assign s00_axi_awready = aw_ready;
  assign s00_axi_wready  = w_ready;
  assign s00_axi_bvalid  = (wr_state_reg == WR_RESP);
  assign s00_axi_bresp   = bresp_reg;
  assign s00_axi_arready = ar_ready;
  assign s00_axi_rvalid  = (rd_state_reg == RD_VALID);
  assign s00_axi_rdata   = rdata_reg;
  assign s00_axi_rresp   = rresp_reg;
  assign start_o         = start_reg;
  assign soft_rst_o      = soft_rst_reg;
  assign irq_o           = irq_reg;

  // Hold readies low for the first cycle after reset is released
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) active_reg <= 1'b0;
    else                  active_reg <= 1'b1;
  end

  // Channel FSM state registers
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wr_state_reg <= WR_COLLECT;
      rd_state_reg <= RD_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  // Write FSM: open each slot while empty, commit once both are held, then wait for bready
  always_comb begin
    wr_state_next = wr_state_reg;
    aw_ready      = 1'b0;
    w_ready       = 1'b0;
    wr_commit     = 1'b0;
    case (wr_state_reg)
      WR_COLLECT: begin
        aw_ready = active_reg && !aw_full_reg;
        w_ready  = active_reg && !w_full_reg;
        if (aw_full_reg && w_full_reg) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s00_axi_bready) wr_state_next = WR_COLLECT;
      end
      default: wr_state_next = WR_COLLECT;
    endcase
  end

  // Read FSM: accept one address, present data until rready
  always_comb begin
    rd_state_next = rd_state_reg;
    ar_ready      = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        ar_ready = active_reg;
        if (s00_axi_arvalid && active_reg) rd_state_next = RD_VALID;
      end
      RD_VALID: begin
        if (s00_axi_rready) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // AW/W holding slots and the B response code
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_full_reg <= 1'b0;
      aw_widx_reg <= '0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      bresp_reg   <= wr_in_map ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_widx_reg <= s00_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s00_axi_wdata;
        w_strb_reg <= s00_axi_wstrb;
      end
    end
  end

  // CFG registers with byte enables; each one drives its slice of cfg_o directly
  for (genvar gi = 0; gi < N_CFG; gi++) begin : g_cfg
    logic [DATA_W-1:0] cfg_reg;

    // Byte-masked update on a committed write to this word
    always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
        cfg_reg <= '0;
      end else if (wr_commit && (wr_widx == 32'(REG_CFG_BASE + gi))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb_reg[b]) cfg_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
        end
      end
    end

    assign cfg_o[gi*DATA_W +: DATA_W] = cfg_reg;
  end

  // Job control: pulses, BUSY/DONE/ERR, cycle counter and the interrupt level
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      irq_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cycles_reg   <= '0;
      start_reg    <= 1'b0;
      soft_rst_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      start_reg    <= 1'b0;
      soft_rst_reg <= 1'b0;
      if (ctrl_wr) irq_en_reg <= w_data_reg[CTRL_IRQ_EN];
      if (busy_reg && (cycles_reg != '1)) cycles_reg <= cycles_reg + DATA_W'(1);

      if (soft_rst_req) begin
        // Soft reset clears job state only; CFG and IRQ_EN survive
        soft_rst_reg <= 1'b1;
        busy_reg     <= 1'b0;
        done_reg     <= 1'b0;
        err_reg      <= 1'b0;
        cycles_reg   <= '0;
      end else if (start_req && !busy_reg) begin
        // A new job overrides a done_i/err_i landing in the same cycle
        start_reg  <= 1'b1;
        busy_reg   <= 1'b1;
        done_reg   <= 1'b0;
        err_reg    <= 1'b0;
        cycles_reg <= '0;
      end else begin
        if (start_req)                            err_reg  <= 1'b1;
        if (status_wr && w_data_reg[STAT_DONE])   done_reg <= 1'b0;
        if (status_wr && w_data_reg[STAT_ERR])    err_reg  <= 1'b0;
        // Engine events come last so a set beats a simultaneous W1C
        if (done_i) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        if (err_i) begin
          busy_reg <= 1'b0;
          err_reg  <= 1'b1;
        end
      end

      irq_reg <= irq_en_reg & (done_reg | err_reg);
    end
  end

  // Read mux over the current register values
  always_comb begin
    rd_widx = 32'(s00_axi_araddr[ADDR_W-1:2]);
    rd_data = '0;
    rd_resp = word_in_map(rd_widx, N_CFG) ? RESP_OKAY : RESP_SLVERR;
    if (rd_widx == 32'(REG_CTRL))    rd_data = DATA_W'({irq_en_reg, 2'b00});
    if (rd_widx == 32'(REG_STATUS))  rd_data = DATA_W'({err_reg, done_reg, busy_reg});
    if (rd_widx == 32'(REG_CYCLES))  rd_data = cycles_reg;
    if (rd_widx == 32'(REG_VERSION)) rd_data = DATA_W'(VERSION);
    for (int i = 0; i < N_CFG; i++) begin
      if (rd_widx == 32'(REG_CFG_BASE + i)) rd_data = cfg_o[i*DATA_W +: DATA_W];
    end
  end

  // Registered read data, captured on the AR handshake
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_data;
      rresp_reg <= rd_resp;
    end
  end

endmodule

// File: tb/tb_npu_csr_axil.sv
// Directed bench for npu_csr_axil: register map, write-channel ordering, job
// control, W1C/set priority, error responses, B back-pressure and mid-transaction reset.
module tb_npu_csr_axil;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         start_o, soft_rst_o, done_i, err_i, irq_o;
  logic [255:0] cfg_o;

  int unsigned tick = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  npu_csr_axil #(.DATA_W(32), .ADDR_W(8), .N_CFG(8), .VERSION(32'h0001_0000)) dut (
    .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),   .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),     .s00_axi_wvalid(wvalid),   .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),   .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),   .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),     .s00_axi_rvalid(rvalid),   .s00_axi_rready(rready),
    .start_o(start_o),        .soft_rst_o(soft_rst_o),   .cfg_o(cfg_o),
    .done_i(done_i),          .err_i(err_i),             .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: handshake timeout (observed none, expected within 20 cycles)", tag);
  endtask

  // Full write with AW and W presented together; bdelay holds bready low after bvalid
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int bdelay, output logic [1:0] resp, output logic st_seen,
                           output logic sr_seen, output logic stable);
    logic hs_aw, hs_w;
    int   guard;
    resp = 2'bxx; st_seen = 1'bx; sr_seen = 1'bx; stable = 1'b1;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    guard = 0;
    while ((awvalid || wvalid) && guard < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
      guard++;
    end
    if (awvalid || wvalid) begin
      timeout("wr_addr_data");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    guard = 0;
    while (!bvalid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bvalid) begin
      timeout("wr_bvalid");
      return;
    end
    st_seen = start_o;
    sr_seen = soft_rst_o;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      if (!bvalid || awready || wready) stable = 1'b0;
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=0x%02h data=0x%08h strb=%b resp=%b start=%b soft=%b",
             addr, data, strb, resp, st_seen, sr_seen);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int guard;
    data = 32'hxxxx_xxxx; resp = 2'bxx;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!arready) begin
      timeout("rd_arready");
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rvalid) begin
      timeout("rd_rvalid");
      return;
    end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    $display("read  addr=0x%02h data=0x%08h resp=%b", addr, data, resp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, br;
    logic        st, sr, stb;
    int unsigned t1;
    int          guard;

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0; done_i = 1'b0; err_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
    chk("rst_pulses_irq", {start_o, soft_rst_o, irq_o}, 3'b000);
    chk("rst_cfg", cfg_o == '0, 1'b1);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    axi_read(8'h0C, rd, rs);
    chk("version", {rs, rd}, {2'b00, 32'h0001_0000});
    axi_read(8'h04, rd, rs);
    chk("status_rst", {rs, rd}, {2'b00, 32'h0});
    chk("irq_idle", irq_o, 1'b0);

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("w_slot_held", {wready, awready}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    awaddr = 8'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("bvalid_not_early", bvalid, 1'b0);
    @(negedge clk);
    chk("bvalid_after_aw", bvalid, 1'b1);
    chk("cfg1_strb", cfg_o[63:32], 32'h00AD_00EF);
    chk("bresp_cfg1", bresp, 2'b00);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_dropped", bvalid, 1'b0);
    axi_read(8'h14, rd, rs);
    chk("rd_cfg1", {rs, rd}, {2'b00, 32'h00AD_00EF});

    // Job start with IRQ_EN, done after 20 busy cycles
    axi_write(8'h00, 32'h5, 4'hF, 0, br, st, sr, stb);
    t1 = tick;
    chk("start_pulse", {st, sr}, 2'b10);
    chk("start_one_cycle", start_o, 1'b0);
    axi_read(8'h04, rd, rs);
    chk("status_busy", rd, 32'h1);
    axi_read(8'h00, rd, rs);
    chk("ctrl_readback", rd, 32'h4);
    while (tick < t1 + 18) @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    chk("irq_lag", irq_o, 1'b0);
    @(negedge clk);
    chk("irq_set", irq_o, 1'b1);
    axi_read(8'h04, rd, rs);
    chk("status_done", rd, 32'h2);
    axi_read(8'h08, rd, rs);
    chk("cycles_20pm1", (rd >= 32'd19) && (rd <= 32'd21), 1'b1);
    repeat (4) @(negedge clk);
    axi_read(8'h08, rd, rs);
    chk("cycles_hold", (rd >= 32'd19) && (rd <= 32'd21), 1'b1);

    // W1C of DONE landing on the same edge as done_i: set wins
    @(negedge clk);
    chk("w1c_slots_open", {awready, wready}, 2'b11);
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    chk("w1c_bvalid", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read(8'h04, rd, rs);
    chk("done_set_wins", rd, 32'h2);
    axi_write(8'h04, 32'h2, 4'hF, 0, br, st, sr, stb);
    axi_read(8'h04, rd, rs);
    chk("done_w1c", rd, 32'h0);
    chk("irq_dropped", irq_o, 1'b0);

    // START while busy, then SOFT_RST+START together
    axi_write(8'h00, 32'h5, 4'hF, 0, br, st, sr, stb);
    chk("start2_pulse", st, 1'b1);
    axi_write(8'h00, 32'h5, 4'hF, 0, br, st, sr, stb);
    chk("start_busy_nopulse", st, 1'b0);
    axi_read(8'h04, rd, rs);
    chk("status_busy_err", rd, 32'h5);
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    axi_read(8'h04, rd, rs);
    chk("status_done_err", rd, 32'h6);
    axi_write(8'h00, 32'h7, 4'hF, 0, br, st, sr, stb);
    chk("soft_only_pulse", {st, sr}, 2'b01);
    axi_read(8'h04, rd, rs);
    chk("soft_status", rd, 32'h0);
    axi_read(8'h08, rd, rs);
    chk("soft_cycles", rd, 32'h0);
    axi_read(8'h00, rd, rs);
    chk("soft_irq_en_kept", rd, 32'h4);
    chk("soft_cfg_kept", cfg_o[63:32], 32'h00AD_00EF);

    // Out-of-map accesses and ignored low address bits
    axi_read(8'h30, rd, rs);
    chk("oom_read", {rs, rd}, {2'b10, 32'h0});
    axi_write(8'h30, 32'hFFFF_FFFF, 4'hF, 0, br, st, sr, stb);
    chk("oom_write_resp", br, 2'b10);
    chk("oom_cfg_untouched", cfg_o[255:64], 192'h0);
    axi_read(8'h17, rd, rs);
    chk("low_bits_ignored", {rs, rd}, {2'b00, 32'h00AD_00EF});

    // B back-pressure
    axi_write(8'h10, 32'h1234_5678, 4'hF, 5, br, st, sr, stb);
    chk("bvalid_stable", stb, 1'b1);
    chk("bp_resp", br, 2'b00);
    chk("cfg0_write", cfg_o[31:0], 32'h1234_5678);

    // Reset dropped while a B response is pending and a job is running
    axi_write(8'h00, 32'h1, 4'hF, 0, br, st, sr, stb);
    chk("job3_start", st, 1'b1);
    @(negedge clk);
    awaddr = 8'h18; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    guard = 0;
    while (!bvalid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bvalid) timeout("rst_mid_bvalid");
    chk("cfg2_pending", cfg_o[95:64], 32'hCAFE_F00D);
    aresetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_bvalid", bvalid, 1'b0);
    chk("rst_mid_cfg", cfg_o == '0, 1'b1);
    chk("rst_mid_ready", {awready, arready}, 2'b00);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(8'h04, rd, rs);
    chk("rst_mid_status", rd, 32'h0);
    axi_read(8'h18, rd, rs);
    chk("rst_mid_cfg2", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
